// File: rtl/de_selector_buf.sv
// Routes one producer word into one of CHANNELS one-entry holding registers,
// selected manually by iSel or by an internal round-robin pointer.
module de_selector_buf #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [WIDTH-1:0]          iC,
  input  logic                      iCValid,
  output logic                      oCReady,
  input  logic                      iAuto,
  input  logic [SEL_W-1:0]          iSel,
  output logic [SEL_W-1:0]          oSelCur,
  output logic [CHANNELS*WIDTH-1:0] oZ,
  output logic [CHANNELS-1:0]       oZValid,
  input  logic [CHANNELS-1:0]       iZReady
);

  // Handshake: a word moves on a rising edge where valid & ready are both
  // high, on the producer side (iCValid/oCReady) and on each consumer side
  // (oZValid[k]/iZReady[k]); ready may depend combinationally on the target.

  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0]       r_full;
  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [SEL_W-1:0]          r_ptr;

  logic [SEL_W-1:0]          w_tgt;
  logic [CHANNELS-1:0]       w_hit;
  logic [CHANNELS-1:0]       w_load;
  logic                      w_ready;
  logic                      w_acc;

  assign w_tgt = iAuto ? r_ptr : iSel;

  // An out-of-range manual select matches no channel, so it is never ready.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_hit[k] = (w_tgt == SEL_W'(k));
    end
  end

  assign w_ready = |(w_hit & (~r_full | iZReady));
  assign w_acc   = iCValid & w_ready;
  assign w_load  = w_hit & {CHANNELS{w_acc}};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_full <= '0;
      r_data <= '0;
      r_ptr  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // A load in the draining cycle keeps the slot full with the new word.
        if (w_load[k]) begin
          r_data[k*WIDTH +: WIDTH] <= iC;
          r_full[k]                <= 1'b1;
        end else if (iZReady[k]) begin
          r_full[k] <= 1'b0;
        end
      end
      if (w_acc && iAuto) begin
        r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + SEL_W'(1);
      end
    end
  end

  assign oCReady = w_ready;
  assign oSelCur = w_tgt;
  assign oZ      = r_data;
  assign oZValid = r_full;

endmodule

// File: tb/tb_de_selector_buf.sv
// Bench for de_selector_buf: a 4-channel and a 3-channel instance driven with
// the same inputs and compared against a per-instance behavioural model.
module tb_de_selector_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c;
  logic        cv;
  logic        auto;
  logic [1:0]  sel;
  logic [3:0]  zr;

  logic        rdy4, rdy3;
  logic [1:0]  selc4, selc3;
  logic [15:0] z4;
  logic [11:0] z3;
  logic [3:0]  zv4;
  logic [2:0]  zv3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  de_selector_buf #(.WIDTH(4), .CHANNELS(4)) dut4 (
    .iClk(clk), .iRst(rst), .iC(c), .iCValid(cv), .oCReady(rdy4),
    .iAuto(auto), .iSel(sel), .oSelCur(selc4), .oZ(z4), .oZValid(zv4),
    .iZReady(zr)
  );

  de_selector_buf #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .iClk(clk), .iRst(rst), .iC(c), .iCValid(cv), .oCReady(rdy3),
    .iAuto(auto), .iSel(sel), .oSelCur(selc3), .oZ(z3), .oZValid(zv3),
    .iZReady(zr[2:0])
  );

  // Reference model: index 0 = 4-channel instance, 1 = 3-channel instance.
  int         nch [2] = '{4, 3};
  logic       m_full [2][4];
  logic [3:0] m_data [2][4];
  int         m_ptr  [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      for (int k = 0; k < 4; k++) begin
        m_full[d][k] = 1'b0;
        m_data[d][k] = 4'h0;
      end
    end
  endfunction

  function automatic int m_tgt(int d);
    return auto ? m_ptr[d] : int'(sel);
  endfunction

  function automatic logic m_rdy(int d);
    int t = m_tgt(d);
    if (t >= nch[d]) return 1'b0;
    return !m_full[d][t] || zr[t];
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int   t   = m_tgt(d);
      logic acc = cv && m_rdy(d);
      for (int k = 0; k < nch[d]; k++) begin
        if (m_full[d][k] && zr[k]) m_full[d][k] = 1'b0;
      end
      if (acc) begin
        m_data[d][t] = c;
        m_full[d][t] = 1'b1;
        if (auto) m_ptr[d] = (m_ptr[d] + 1) % nch[d];
      end
    end
  endfunction

  function automatic logic [15:0] exp_z(int d);
    logic [15:0] v = '0;
    for (int k = 0; k < nch[d]; k++) v[k*4 +: 4] = m_data[d][k];
    return v;
  endfunction

  function automatic logic [3:0] exp_zv(int d);
    logic [3:0] v = '0;
    for (int k = 0; k < nch[d]; k++) v[k] = m_full[d][k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; auto = 1'b1; cv = 1'b0; sel = 2'd0; c = 4'h0; zr = 4'h0;
    #1;
    model_reset();
    n_total++; if (zv4 !== 4'h0) $display("FAIL reset_zv4 got %b want 0000", zv4); else n_pass++;
    n_total++; if (z4 !== 16'h0) $display("FAIL reset_z4 got %h want 0000", z4); else n_pass++;
    n_total++; if (zv3 !== 3'h0) $display("FAIL reset_zv3 got %b want 000", zv3); else n_pass++;
    n_total++; if (z3 !== 12'h0) $display("FAIL reset_z3 got %h want 000", z3); else n_pass++;
    n_total++; if (selc4 !== 2'd0) $display("FAIL reset_selc4 got %0d want 0", selc4); else n_pass++;
    n_total++; if (selc3 !== 2'd0) $display("FAIL reset_selc3 got %0d want 0", selc3); else n_pass++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_manual_load();
    do_reset();
    auto = 1'b0; zr = 4'h0; sel = 2'd2; c = 4'hA; cv = 1'b1;
    #1;
    n_total++; if (rdy4 !== 1'b1) $display("FAIL load_ready got %b want 1", rdy4); else n_pass++;
    tick();
    cv = 1'b0; c = 4'h0;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (zv4 !== 4'b0100) $display("FAIL load_zv cyc%0d got %b want 0100", i, zv4); else n_pass++;
      n_total++; if (z4[11:8] !== 4'hA) $display("FAIL load_z cyc%0d got %h want a", i, z4[11:8]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    auto = 1'b0; zr = 4'h0; sel = 2'd1; c = 4'h3; cv = 1'b1;
    tick();
    c = 4'h5;
    #1;
    n_total++; if (rdy4 !== 1'b0) $display("FAIL bp_ready_full got %b want 0", rdy4); else n_pass++;
    tick();
    n_total++; if (z4[7:4] !== 4'h3) $display("FAIL bp_hold got %h want 3", z4[7:4]); else n_pass++;
    n_total++; if (zv4[1] !== 1'b1) $display("FAIL bp_valid got %b want 1", zv4[1]); else n_pass++;
    zr = 4'b0010;
    #1;
    n_total++; if (rdy4 !== 1'b1) $display("FAIL bp_ready_drain got %b want 1", rdy4); else n_pass++;
    tick();
    n_total++; if (z4[7:4] !== 4'h5) $display("FAIL bp_refill got %h want 5", z4[7:4]); else n_pass++;
    n_total++; if (zv4[1] !== 1'b1) $display("FAIL bp_refill_valid got %b want 1", zv4[1]); else n_pass++;
    cv = 1'b0; zr = 4'h0;
  endtask

  task automatic test_round_robin();
    do_reset();
    auto = 1'b1; zr = 4'hF; cv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c = 4'(i + 1);
      #1;
      n_total++; if (selc4 !== 2'(i % 4)) $display("FAIL rr_sel4 w%0d got %0d want %0d", i, selc4, i % 4); else n_pass++;
      n_total++; if (selc3 !== 2'(i % 3)) $display("FAIL rr_sel3 w%0d got %0d want %0d", i, selc3, i % 3); else n_pass++;
      tick();
      n_total++; if (z4[(i%4)*4 +: 4] !== 4'(i + 1)) $display("FAIL rr_land w%0d got %h want %h", i, z4[(i%4)*4 +: 4], i + 1); else n_pass++;
      n_total++; if (zv4 !== exp_zv(0)) $display("FAIL rr_zv w%0d got %b want %b", i, zv4, exp_zv(0)); else n_pass++;
    end
    cv = 1'b0;
    #1;
    n_total++; if (selc4 !== 2'd1) $display("FAIL rr_sel_end got %0d want 1", selc4); else n_pass++;
    zr = 4'h0;
  endtask

  task automatic test_auto_stall();
    do_reset();
    zr = 4'h0; auto = 1'b1; c = 4'h7; cv = 1'b1;
    tick();
    auto = 1'b0; sel = 2'd1; c = 4'h8;
    tick();
    auto = 1'b1; c = 4'h9;
    #1;
    n_total++; if (selc4 !== 2'd1) $display("FAIL stall_sel got %0d want 1", selc4); else n_pass++;
    n_total++; if (rdy4 !== 1'b0) $display("FAIL stall_ready got %b want 0", rdy4); else n_pass++;
    tick();
    n_total++; if (selc4 !== 2'd1) $display("FAIL stall_ptr_hold got %0d want 1", selc4); else n_pass++;
    n_total++; if (z4[7:4] !== 4'h8) $display("FAIL stall_data got %h want 8", z4[7:4]); else n_pass++;
    zr = 4'b0010;
    #1;
    n_total++; if (rdy4 !== 1'b1) $display("FAIL stall_release got %b want 1", rdy4); else n_pass++;
    tick();
    n_total++; if (selc4 !== 2'd2) $display("FAIL stall_ptr_adv got %0d want 2", selc4); else n_pass++;
    n_total++; if (z4[7:4] !== 4'h9) $display("FAIL stall_new got %h want 9", z4[7:4]); else n_pass++;
    cv = 1'b0; zr = 4'h0;
  endtask

  task automatic test_async_reset();
    do_reset();
    zr = 4'h0; auto = 1'b0; sel = 2'd3; c = 4'h3; cv = 1'b1;
    tick();
    auto = 1'b1; c = 4'hC;
    repeat (3) tick();
    cv = 1'b0; zr = 4'b0110;
    tick();
    zr = 4'h0;
    #1;
    n_total++; if (zv4 !== 4'b1001) $display("FAIL ar_pre_zv got %b want 1001", zv4); else n_pass++;
    n_total++; if (selc4 !== 2'd3) $display("FAIL ar_pre_sel got %0d want 3", selc4); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (zv4 !== 4'h0) $display("FAIL ar_zv got %b want 0000", zv4); else n_pass++;
    n_total++; if (z4 !== 16'h0) $display("FAIL ar_z got %h want 0000", z4); else n_pass++;
    n_total++; if (selc4 !== 2'd0) $display("FAIL ar_sel got %0d want 0", selc4); else n_pass++;
    n_total++; if (zv3 !== 3'h0) $display("FAIL ar_zv3 got %b want 000", zv3); else n_pass++;
    model_reset();
    rst = 1'b0; c = 4'h6; cv = 1'b1;
    #1;
    n_total++; if (rdy4 !== 1'b1) $display("FAIL ar_post_ready got %b want 1", rdy4); else n_pass++;
    tick();
    n_total++; if (zv4 !== 4'b0001) $display("FAIL ar_post_zv got %b want 0001", zv4); else n_pass++;
    n_total++; if (z4[3:0] !== 4'h6) $display("FAIL ar_post_z got %h want 6", z4[3:0]); else n_pass++;
    cv = 1'b0;
  endtask

  task automatic test_nonpow2();
    do_reset();
    auto = 1'b0; sel = 2'd3; c = 4'hE; cv = 1'b1; zr = 4'h0;
    #1;
    n_total++; if (rdy3 !== 1'b0) $display("FAIL np2_oor_ready got %b want 0", rdy3); else n_pass++;
    n_total++; if (rdy4 !== 1'b1) $display("FAIL np2_inr_ready got %b want 1", rdy4); else n_pass++;
    tick();
    n_total++; if (zv3 !== 3'b000) $display("FAIL np2_oor_zv got %b want 000", zv3); else n_pass++;
    auto = 1'b1; zr = 4'hF;
    for (int i = 0; i < 4; i++) begin
      c = 4'(i + 1);
      #1;
      n_total++; if (selc3 !== 2'(i % 3)) $display("FAIL np2_wrap_sel w%0d got %0d want %0d", i, selc3, i % 3); else n_pass++;
      tick();
      n_total++; if (z3[(i%3)*4 +: 4] !== 4'(i + 1)) $display("FAIL np2_land w%0d got %h want %h", i, z3[(i%3)*4 +: 4], i + 1); else n_pass++;
    end
    cv = 1'b0; zr = 4'h0;
  endtask

  task automatic test_random();
    logic [15:0] e4, e3;
    logic [3:0]  v4, v3;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cv   = 1'($urandom_range(0, 3) != 0);
      auto = 1'($urandom_range(0, 3) != 0);
      sel  = 2'($urandom_range(0, 3));
      c    = 4'($urandom);
      zr   = 4'($urandom);
      #1;
      n_total++; if (rdy4 !== m_rdy(0)) $display("FAIL rnd_rdy4 c%0d got %b want %b", i, rdy4, m_rdy(0)); else n_pass++;
      n_total++; if (rdy3 !== m_rdy(1)) $display("FAIL rnd_rdy3 c%0d got %b want %b", i, rdy3, m_rdy(1)); else n_pass++;
      n_total++; if (selc4 !== 2'(m_tgt(0))) $display("FAIL rnd_sel4 c%0d got %0d want %0d", i, selc4, m_tgt(0)); else n_pass++;
      tick();
      e4 = exp_z(0); e3 = exp_z(1); v4 = exp_zv(0); v3 = exp_zv(1);
      n_total++; if (zv4 !== v4) $display("FAIL rnd_zv4 c%0d got %b want %b", i, zv4, v4); else n_pass++;
      n_total++; if (z4 !== e4) $display("FAIL rnd_z4 c%0d got %h want %h", i, z4, e4); else n_pass++;
      n_total++; if (zv3 !== v3[2:0]) $display("FAIL rnd_zv3 c%0d got %b want %b", i, zv3, v3[2:0]); else n_pass++;
      n_total++; if (z3 !== e3[11:0]) $display("FAIL rnd_z3 c%0d got %h want %h", i, z3, e3[11:0]); else n_pass++;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        n_total++; if (zv4 !== 4'h0) $display("FAIL rnd_reset_zv4 c%0d got %b want 0000", i, zv4); else n_pass++;
        model_reset();
        rst = 1'b0;
        #1;
      end
    end
    cv = 1'b0; zr = 4'h0;
  endtask

  initial begin
    test_reset();
    test_manual_load();
    test_backpressure();
    test_round_robin();
    test_auto_stall();
    test_async_reset();
    test_nonpow2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/de_selector_buf.md
Name: de_selector_buf

Overview:
Parametrised successor to the 1-to-4 demultiplexer. It routes a WIDTH-bit input word to one of CHANNELS outputs. Each output has a one-entry holding register with a valid/ready handshake. Besides externally selected (manual) routing, it supports an auto mode in which an internal round-robin pointer distributes consecutive words across the channels. It sits between a single producer and several independent consumers.

Parameters:
WIDTH, 1, data bits per word
CHANNELS, 4, number of output channels (>=2; need not be a power of two)
SEL_W, $clog2(CHANNELS), select/pointer width (derived; do not override)

Ports:
iClk  input  1  clock, rising edge
iRst  input  1  reset, asynchronous, active-high
iC  input  WIDTH  input data word
iCValid  input  1  producer has a word on iC
oCReady  output  1  block accepts iC this cycle
iAuto  input  1  0 = manual (iSel routes), 1 = round-robin pointer routes
iSel  input  SEL_W  manual target channel
oSelCur  output  SEL_W  current target channel, combinational
oZ  output  CHANNELS*WIDTH  channel k data on bits [k*WIDTH +: WIDTH]
oZValid  output  CHANNELS  channel k holds a word
iZReady  input  CHANNELS  consumer k takes its word this cycle

Behaviour:
- Target: t = iAuto ? ptr : iSel. oSelCur = t. A change on iAuto takes effect combinationally in the same cycle.
- Out-of-range target (iSel >= CHANNELS, manual mode only): oCReady = 0. Nothing is accepted and no state changes.
- Ready: oCReady = (t in range) & (~full[t] | iZReady[t]). This allows pass-through refill in the cycle the channel drains.
- Accept: iCValid & oCReady at a rising edge. Then data[t] <= iC and full[t] <= 1.
- Drain: full[k] & iZReady[k] at an edge sets full[k] <= 0, unless channel k is also accepting in that edge; then full[k] stays 1 with the new data.
- iZReady[k] while full[k] = 0 is ignored.
- oZValid = full. oZ slice k = data[k], held stable while oZValid[k] & ~iZReady[k].
- Latency: a word accepted at edge n appears as oZValid[t] = 1 right after edge n (1 cycle).
- Only one channel can be loaded per cycle. Any number of channels may drain in the same cycle.
- Pointer: ptr advances only on an accept while iAuto = 1. Wrap rule: CHANNELS-1 goes to 0. ptr never skips a full channel; it waits.
- In manual mode ptr holds its value. Switching back to auto resumes from the held ptr.
- Reset (iRst = 1, any time, independent of iClk): full = 0, all data = 0, ptr = 0. Outputs go immediately to oZValid = 0, oZ = 0, and oSelCur = 0 when iAuto = 1.
- Words buffered when reset asserts mid-operation are discarded. The first accept after iRst is deasserted occurs at the next edge.
- iCValid = 0: no state change apart from drains.

Test Plan:
1. Manual load (WIDTH=4, CHANNELS=4): reset, iAuto=0, iSel=2, iC=4'hA, iCValid=1 for 1 cycle, iZReady=0 -> after the edge oZValid=4'b0100 and oZ[11:8]=4'hA; both stay stable for 3 cycles.
2. Backpressure and refill: channel 1 full with 4'h3, iZReady[1]=0, iSel=1, iC=4'h5 -> oCReady=0 and oZ[7:4] stays 4'h3. Then iZReady[1]=1 in the same cycle as the accept -> oZ[7:4]=4'h5, oZValid[1] stays 1.
3. Round-robin: iAuto=1, all iZReady=1, words 1,2,3,4,5 on consecutive cycles -> they land on channels 0,1,2,3,0; oSelCur sequence is 0,1,2,3,0,1.
4. Auto stall: iAuto=1, ptr=1, channel 1 full, iZReady[1]=0 -> oCReady=0 and ptr stays 1. Raise iZReady[1] -> accept, ptr goes to 2.
5. Async reset mid-operation: channels 0 and 3 full, ptr=3, assert iRst between edges -> oZValid=0 and oZ=0 immediately, oSelCur=0. After release the first word goes to channel 0.
6. Non-power-of-two (CHANNELS=3): manual iSel=3, iCValid=1 -> oCReady=0, no oZValid change. Auto mode wraps 0,1,2,0.
